// File: rtl/xbee_pkg.sv
// Shared types and helpers for the XBee UART receive path: FSM state encoding,
// oversample divider calculation and mid-bit sampling indices.
package xbee_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned den;
        den = baud * oversample;
        return (clk_freq + den / 32'd2) / den;
    endfunction

    // Three sample points centred on mid-bit: OVERSAMPLE/2 - 1, /2, /2 + 1.
    function automatic int unsigned sample_early(input int unsigned oversample);
        return oversample / 32'd2 - 32'd1;
    endfunction

    function automatic int unsigned sample_mid(input int unsigned oversample);
        return oversample / 32'd2;
    endfunction

    function automatic int unsigned sample_late(input int unsigned oversample);
        return oversample / 32'd2 + 32'd1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, held at phase 0
// while clear is high so the bit phase follows the detected start edge.
module rx_tick_gen #(
    parameter int unsigned CLKFREQ    = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    import xbee_pkg::*;

    localparam int unsigned DIV = calc_div(CLKFREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    logic [CW-1:0] div_cnt_r;
    logic          tick_r;

    assign tick = tick_r;

    // Divider counter and registered tick pulse.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt_r <= CNT_ZERO;
            tick_r    <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= CNT_ZERO;
            tick_r    <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_ONE;
            tick_r    <= 1'b0;
        end
    end

endmodule

// File: rtl/xbee_receiver.sv
// 8N1 UART receiver for the XBee DOUT line: 2-flop synchronizer, 16x oversampled
// majority-vote bit decisions, framing-error reporting and break handling.
module xbee_receiver #(
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLKFREQ    = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RxD,
    output logic [DATA_WIDTH-1:0] RxD_data,
    output logic                  RxD_data_ready,
    output logic                  RxD_frame_error,
    output logic                  RxD_busy
);
    import xbee_pkg::*;

    localparam int unsigned OW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_WIDTH > 32'd1) ? $clog2(DATA_WIDTH) : 32'd1;
    localparam logic [OW-1:0] OS_EARLY = OW'(sample_early(OVERSAMPLE));
    localparam logic [OW-1:0] OS_MID   = OW'(sample_mid(OVERSAMPLE));
    localparam logic [OW-1:0] OS_LATE  = OW'(sample_late(OVERSAMPLE));
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 32'd1);
    localparam logic [OW-1:0] OS_ONE   = OW'(32'd1);
    localparam logic [OW-1:0] OS_ZERO  = OW'(32'd0);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 32'd1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(32'd1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(32'd0);

    logic [1:0]            sync_r;
    logic                  rx_s;
    logic                  tick_s;
    logic                  clear_s;
    rx_state_t             state_r, state_s;
    logic [OW-1:0]         os_cnt_r, os_cnt_s;
    logic [BW-1:0]         bit_cnt_r, bit_cnt_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic [1:0]            samp_r, samp_s;
    logic                  ready_r, ready_s;
    logic                  ferr_r, ferr_s;
    logic                  busy_r;
    logic                  decide_s;
    logic                  wrap_s;
    logic                  bit_val_s;

    assign rx_s    = sync_r[1];
    assign clear_s = (state_r == IDLE);

    assign RxD_data        = data_r;
    assign RxD_data_ready  = ready_r;
    assign RxD_frame_error = ferr_r;
    assign RxD_busy        = busy_r;

    rx_tick_gen #(
        .CLKFREQ    (CLKFREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], RxD};
        end
    end

    // Next-state, sampling, shifting and pulse generation.
    always_comb begin
        state_s   = state_r;
        os_cnt_s  = os_cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        samp_s    = samp_r;
        data_s    = data_r;
        ready_s   = 1'b0;
        ferr_s    = 1'b0;
        decide_s  = tick_s && (os_cnt_r == OS_LATE);
        wrap_s    = tick_s && (os_cnt_r == OS_LAST);
        bit_val_s = maj3(samp_r[0], samp_r[1], rx_s);

        if (tick_s) begin
            if (wrap_s) begin
                os_cnt_s = OS_ZERO;
            end else begin
                os_cnt_s = os_cnt_r + OS_ONE;
            end
            if (os_cnt_r == OS_EARLY) begin
                samp_s[0] = rx_s;
            end else if (os_cnt_r == OS_MID) begin
                samp_s[1] = rx_s;
            end else begin
                samp_s = samp_r;
            end
        end else begin
            os_cnt_s = os_cnt_r;
        end

        case (state_r)
            IDLE: begin
                os_cnt_s  = OS_ZERO;
                bit_cnt_s = BIT_ZERO;
                if (!rx_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (decide_s && bit_val_s) begin
                    state_s = IDLE;
                end else if (wrap_s) begin
                    state_s   = DATA;
                    bit_cnt_s = BIT_ZERO;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (decide_s) begin
                    shift_s = {bit_val_s, shift_r[DATA_WIDTH-1:1]};
                end else begin
                    shift_s = shift_r;
                end
                if (wrap_s && (bit_cnt_r == BIT_LAST)) begin
                    state_s   = STOP;
                    bit_cnt_s = BIT_ZERO;
                end else if (wrap_s) begin
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end else begin
                    bit_cnt_s = bit_cnt_r;
                end
            end
            // Leave STOP right at the decision so a back-to-back start edge is caught.
            STOP: begin
                if (decide_s && bit_val_s) begin
                    data_s  = shift_r;
                    ready_s = 1'b1;
                    state_s = IDLE;
                end else if (decide_s) begin
                    ferr_s  = 1'b1;
                    state_s = BREAK;
                end else begin
                    state_s = STOP;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            os_cnt_r  <= OS_ZERO;
            bit_cnt_r <= BIT_ZERO;
            shift_r   <= {DATA_WIDTH{1'b0}};
            samp_r    <= 2'b00;
            data_r    <= {DATA_WIDTH{1'b0}};
            ready_r   <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            os_cnt_r  <= os_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            samp_r    <= samp_s;
            data_r    <= data_s;
            ready_r   <= ready_s;
            ferr_r    <= ferr_s;
            busy_r    <= (state_s != IDLE);
        end
    end

endmodule
